// File: rtl/snoop_pkg.sv
// Shared types for the snoop bus initiator: bus operation codes, snoop results and FSM states.
package snoop_pkg;

    typedef enum logic [7:0] {
        READ       = 8'h01,
        WRITE      = 8'h02,
        INVALIDATE = 8'h03,
        RWIM       = 8'h04
    } bus_op_e;

    typedef enum logic [1:0] {
        NOHIT = 2'b00,
        HIT   = 2'b01,
        HITM  = 2'b10
    } snoop_e;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StDrive,
        StResp
    } snoop_state_e;

    localparam logic [1:0] SnoopIllegal = 2'b11;

endpackage

// File: rtl/snoop_tristate_driver.sv
// Output-enable driver for the shared address bus and operation bus; both float when not enabled.
module snoop_tristate_driver
    import snoop_pkg::*;
#(
    parameter int unsigned LINE_W = 512
) (
    input  logic              i_oe,
    input  logic [LINE_W+7:0] i_data,
    inout  wire  [LINE_W-1:0] io_addr_bus,
    inout  wire  [7:0]        io_op_bus
);

    assign io_addr_bus = i_oe ? i_data[LINE_W-1:0]      : {LINE_W{1'bz}};
    assign io_op_bus   = i_oe ? i_data[LINE_W+7:LINE_W] : 8'hzz;

endmodule

// File: rtl/snoop_bus_initiator.sv
// Initiator end of the shared snoop bus: arbitrate, drive op/address, settle, sample snoop result.
// Optional result counters are built when SNOOP_STATS_EN is defined.
module snoop_bus_initiator
    import snoop_pkg::*;
#(
    parameter int unsigned LINE_SIZE  = 512,
    parameter int unsigned SNOOP_WAIT = 2
`ifdef SNOOP_STATS_EN
    ,
    parameter int unsigned CNT_W      = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_op,
    input  logic [LINE_SIZE-1:0] req_addr,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    inout  wire  [LINE_SIZE-1:0] sharedBus,
    inout  wire  [7:0]           sharedOperationBus,
    input  logic [1:0]           snoopBus,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_snoop,
    output logic                 rsp_err
`ifdef SNOOP_STATS_EN
    ,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     hitm_cnt,
    output logic [CNT_W-1:0]     nohit_cnt
`endif
);

    localparam int unsigned WAIT_W = (SNOOP_WAIT > 1) ? $clog2(SNOOP_WAIT) : 1;

    snoop_state_e         r_state;
    logic                 r_req_ready;
    logic                 r_bus_req;
    logic                 r_drive;
    logic                 r_rsp_valid;
    logic [1:0]           r_rsp_snoop;
    logic                 r_rsp_err;
    logic [WAIT_W-1:0]    r_wait;
    logic [7:0]           r_op;
    logic [LINE_SIZE-1:0] r_addr;
    logic                 w_oe;
`ifdef SNOOP_STATS_EN
    logic [CNT_W-1:0]     r_hit_cnt;
    logic [CNT_W-1:0]     r_hitm_cnt;
    logic [CNT_W-1:0]     r_nohit_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b1;
            r_bus_req   <= 1'b0;
            r_drive     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_snoop <= NOHIT;
            r_rsp_err   <= 1'b0;
            r_wait      <= '0;
            r_op        <= '0;
            r_addr      <= '0;
`ifdef SNOOP_STATS_EN
            r_hit_cnt   <= '0;
            r_hitm_cnt  <= '0;
            r_nohit_cnt <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_valid && r_req_ready) begin
                        r_op        <= req_op;
                        r_addr      <= req_addr;
                        r_req_ready <= 1'b0;
                        r_bus_req   <= 1'b1;
                        r_state     <= StArb;
                    end
                end
                StArb: begin
                    if (bus_gnt) begin
                        r_drive <= 1'b1;
                        r_wait  <= WAIT_W'(SNOOP_WAIT - 1);
                        r_state <= StDrive;
                    end
                end
                StDrive: begin
                    // Grant loss here is ignored: once driving, the transaction runs to completion.
                    if (r_wait == '0) begin
                        r_rsp_snoop <= snoopBus;
                        r_rsp_err   <= (snoopBus == SnoopIllegal);
                        r_drive     <= 1'b0;
                        r_bus_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
`ifdef SNOOP_STATS_EN
                        if (snoopBus == HIT) begin
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                        end else if (snoopBus == HITM) begin
                            r_hitm_cnt <= r_hitm_cnt + 1'b1;
                        end else if (snoopBus == NOHIT) begin
                            r_nohit_cnt <= r_nohit_cnt + 1'b1;
                        end
`endif
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_oe      = r_drive;
    assign req_ready = r_req_ready;
    assign bus_req   = r_bus_req;
    assign rsp_valid = r_rsp_valid;
    assign rsp_snoop = r_rsp_snoop;
    assign rsp_err   = r_rsp_err;
`ifdef SNOOP_STATS_EN
    assign hit_cnt   = r_hit_cnt;
    assign hitm_cnt  = r_hitm_cnt;
    assign nohit_cnt = r_nohit_cnt;
`endif

    snoop_tristate_driver #(
        .LINE_W (LINE_SIZE)
    ) u_drv (
        .i_oe        (w_oe),
        .i_data      ({r_op, r_addr}),
        .io_addr_bus (sharedBus),
        .io_op_bus   (sharedOperationBus)
    );

endmodule

// File: tb/tb_snoop_bus_initiator.sv
// Self-checking bench for snoop_bus_initiator: vector table, reset-abort sequence, randomized ops.
// Counter checks are compiled in when SNOOP_STATS_EN is defined.
module tb_snoop_bus_initiator;
    import snoop_pkg::*;

    localparam int unsigned LS = 512;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_op;
    logic [LS-1:0] req_addr;
    logic          bus_req;
    logic          bus_gnt;
    wire  [LS-1:0] sharedBus;
    wire  [7:0]    sharedOperationBus;
    logic [1:0]    snoopBus;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_snoop;
    logic          rsp_err;
`ifdef SNOOP_STATS_EN
    logic [31:0]   hit_cnt, hitm_cnt, nohit_cnt;
`endif

    always #5 clk = ~clk;

    snoop_bus_initiator #(
        .LINE_SIZE  (LS),
        .SNOOP_WAIT (SW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_addr           (req_addr),
        .bus_req            (bus_req),
        .bus_gnt            (bus_gnt),
        .sharedBus          (sharedBus),
        .sharedOperationBus (sharedOperationBus),
        .snoopBus           (snoopBus),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_snoop          (rsp_snoop),
        .rsp_err            (rsp_err)
`ifdef SNOOP_STATS_EN
        ,
        .hit_cnt            (hit_cnt),
        .hitm_cnt           (hitm_cnt),
        .nohit_cnt          (nohit_cnt)
`endif
    );

    // Drive activity of the tristate buses (a 2-state simulator cannot show 'z on the wires).
    wire oe = dut.w_oe;

    int n_cmp = 0;
    int n_bad = 0;
    int model_cnt [4];

    typedef struct {
        logic [7:0] op;
        logic [3:0] nib;
        int         gnt_delay;
        logic [1:0] snoop;
        int         hold;
        logic [1:0] exp_snoop;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LS-1:0] rand_addr(input logic [3:0] nib);
        logic [LS-1:0] a;
        for (int i = 0; i < LS / 32; i++) a[i*32 +: 32] = $urandom;
        a[3:0] = nib;
        return a;
    endfunction

    task automatic run_txn(input logic [7:0] op, input logic [LS-1:0] addr, input int d,
                           input logic [1:0] sv, input int hold, input logic [1:0] exp_snoop,
                           input logic exp_err, input int exp_lat);
        int edges, drv, breq, arb, badval, rdy_bad, unstable;
        @(negedge clk);
        chk("ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        snoopBus  = sv;
        bus_gnt   = (d == 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ready_busy", req_ready, 1'b0);
        edges = 1; drv = 0; breq = 0; arb = 0; badval = 0; rdy_bad = 0;
        while (!rsp_valid && edges < 100) begin
            if (oe) begin
                drv++;
                if (sharedBus !== addr || sharedOperationBus !== op) badval++;
            end
            if (bus_req) breq++;
            if (bus_req && !oe) arb++;
            if (req_ready) rdy_bad++;
            if (edges == d + 1) bus_gnt = 1'b1;
            @(negedge clk);
            edges++;
        end
        bus_gnt = 1'b0;
        chk("latency", edges - 1, exp_lat);
        chk("drive_cycles", drv, SW);
        chk("arb_cycles", arb, d + 1);
        chk("bus_req_cycles", breq, d + 1 + SW);
        chk("bus_value_bad", badval, 0);
        chk("ready_during_txn", rdy_bad, 0);
        chk("released_at_rsp", {bus_req, oe}, 2'b00);
        chk("rsp_snoop", rsp_snoop, exp_snoop);
        chk("rsp_err", rsp_err, exp_err);
        if (!exp_err) model_cnt[sv]++;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_snoop !== exp_snoop || rsp_err !== exp_err || req_ready)
                unstable++;
        end
        chk("rsp_hold_stable", unstable, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        int waited, stray;
        logic [1:0] sv;
        int d;

        vecs[0] = '{READ,       4'h2, 0, 2'b01, 0, 2'b01, 1'b0, 3};
        vecs[1] = '{RWIM,       4'hC, 5, 2'b10, 1, 2'b10, 1'b0, 8};
        vecs[2] = '{WRITE,      4'h4, 1, 2'b00, 2, 2'b00, 1'b0, 4};
        vecs[3] = '{INVALIDATE, 4'h0, 0, 2'b11, 6, 2'b11, 1'b1, 3};
        vecs[4] = '{8'hA5,      4'h2, 2, 2'b01, 0, 2'b01, 1'b0, 5};
        vecs[5] = '{8'hFF,      4'h8, 3, 2'b10, 3, 2'b10, 1'b0, 6};
        for (int i = 0; i < 4; i++) model_cnt[i] = 0;

        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0;
        bus_gnt = 1'b0; snoopBus = 2'b00; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", req_ready, 1'b1);
        chk("reset_bus_req", bus_req, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_oe", oe, 1'b0);
        chk("reset_rsp", {rsp_snoop, rsp_err}, 3'b000);
        reset_n = 1'b1;

        foreach (vecs[i])
            run_txn(vecs[i].op, rand_addr(vecs[i].nib), vecs[i].gnt_delay, vecs[i].snoop,
                    vecs[i].hold, vecs[i].exp_snoop, vecs[i].exp_err, vecs[i].exp_lat);

        // Reset while driving: must release immediately and never respond.
        @(negedge clk);
        req_valid = 1'b1; req_op = READ; req_addr = rand_addr(4'h6);
        bus_gnt = 1'b1; snoopBus = 2'b01;
        @(negedge clk);
        req_valid = 1'b0;
        waited = 0;
        while (!oe && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_reached_drive", oe, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_released", {oe, bus_req, rsp_valid, req_ready}, 4'b0001);
        reset_n = 1'b1;
        bus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) model_cnt[i] = 0;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || bus_req) stray++;
        end
        chk("abort_no_response", stray, 0);
        run_txn(WRITE, rand_addr(4'h2), 0, 2'b10, 1, 2'b10, 1'b0, 3);

        for (int n = 0; n < 20; n++) begin
            sv = 2'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 4));
            run_txn(8'($urandom), rand_addr(4'($urandom_range(0, 2) * 2)), d, sv,
                    int'($urandom_range(0, 3)), sv, sv == 2'b11, d + 1 + SW);
        end

`ifdef SNOOP_STATS_EN
        chk("hit_cnt", hit_cnt, model_cnt[1]);
        chk("hitm_cnt", hitm_cnt, model_cnt[2]);
        chk("nohit_cnt", nohit_cnt, model_cnt[0]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
